// File: rtl/spi_ram_ctrl_if.sv
// rtl/spi_ram_ctrl_if.sv - command/response link between the SPI slave and spi_ram_ctrl
interface spi_ram_ctrl_if;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       err;

  modport master (
    output din,
    output rx_valid,
    input  dout,
    input  tx_valid,
    input  err
  );

  modport slave (
    input  din,
    input  rx_valid,
    output dout,
    output tx_valid,
    output err
  );
endinterface

// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - command-decoding byte RAM behind the SPI slave
// Executes WR_ADDR/WR_DATA/RD_ADDR/RD_DATA words, auto-incrementing both pointers.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input logic           clk,
  input logic           rst_n,
  spi_ram_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_t;

  typedef enum logic {
    UNARMED = 1'b0,
    ARMED   = 1'b1
  } rd_state_t;

  rd_state_t            rd_state;
  rd_state_t            rd_state_next;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [7:0]           dout_q;
  logic                 tx_valid_q;
  logic                 err_q;
  logic [7:0]           mem [MEM_DEPTH];

  opcode_t              opcode;
  logic [ADDR_SIZE-1:0] cmd_addr;
  logic                 do_wr_addr;
  logic                 do_wr_data;
  logic                 do_rd_addr;
  logic                 do_rd_data;
  logic                 do_rd_err;

  assign opcode   = opcode_t'(bus.din[9:8]);
  assign cmd_addr = bus.din[ADDR_SIZE-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= UNARMED;
    end else begin
      rd_state <= rd_state_next;
    end
  end

  // A read-data command only produces data once an RD_ADDR has armed the read side.
  always_comb begin
    rd_state_next = rd_state;
    do_wr_addr    = 1'b0;
    do_wr_data    = 1'b0;
    do_rd_addr    = 1'b0;
    do_rd_data    = 1'b0;
    do_rd_err     = 1'b0;
    if (bus.rx_valid) begin
      unique case (opcode)
        OP_WR_ADDR: do_wr_addr = 1'b1;
        OP_WR_DATA: do_wr_data = 1'b1;
        OP_RD_ADDR: begin
          do_rd_addr    = 1'b1;
          rd_state_next = ARMED;
        end
        OP_RD_DATA: begin
          if (rd_state == ARMED) begin
            do_rd_data = 1'b1;
          end else begin
            do_rd_err = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
    end else if (do_wr_addr) begin
      wr_addr <= cmd_addr;
    end else if (do_wr_data) begin
      wr_addr <= wr_addr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr    <= '0;
      dout_q     <= 8'h00;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      tx_valid_q <= do_rd_data;
      err_q      <= do_rd_err;
      if (do_rd_addr) begin
        rd_addr <= cmd_addr;
      end else if (do_rd_data) begin
        rd_addr <= rd_addr + 1'b1;
        dout_q  <= mem[rd_addr];
      end
    end
  end

  // Storage is deliberately left out of reset so it maps onto a plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr_data) begin
      mem[wr_addr] <= bus.din[7:0];
    end
  end

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb/tb_spi_ram_ctrl.sv - directed self-checking bench for spi_ram_ctrl
module tb_spi_ram_ctrl;

  logic clk;
  logic rst_n;
  spi_ram_ctrl_if bus();

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] WA = 2'b00, WD = 2'b01, RA = 2'b10, RD = 2'b11;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: byte store keyed by address, pointers as plain integers.
  logic [7:0] m_mem [int];
  int         m_wr, m_rd;
  bit         m_armed;
  bit         exp_tx, exp_err, exp_dout_known;
  logic [7:0] exp_dout;
  bit         checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_armed = 1'b0;
    exp_tx = 1'b0; exp_err = 1'b0;
    exp_dout = 8'h00; exp_dout_known = 1'b1;
  endtask

  task automatic model_apply(input logic [1:0] op, input logic [7:0] pl);
    exp_tx = 1'b0; exp_err = 1'b0;
    case (op)
      WA: m_wr = int'(pl) % 256;
      WD: begin m_mem[m_wr] = pl; m_wr = (m_wr + 1) % 256; end
      RA: begin m_rd = int'(pl) % 256; m_armed = 1'b1; end
      RD: begin
        if (m_armed) begin
          exp_tx = 1'b1;
          exp_dout_known = m_mem.exists(m_rd);
          if (exp_dout_known) exp_dout = m_mem[m_rd];
          m_rd = (m_rd + 1) % 256;
        end else begin
          exp_err = 1'b1;
        end
      end
      default: ;
    endcase
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic cmd(input logic [1:0] op, input logic [7:0] pl);
    bus.din = {op, pl};
    bus.rx_valid = 1'b1;
    @(posedge clk);
    model_apply(op, pl);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.rx_valid = 1'b0;
      bus.din = 10'($urandom);
      @(posedge clk);
      exp_tx = 1'b0; exp_err = 1'b0;
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("cyc_tx_valid", {31'b0, bus.tx_valid}, {31'b0, exp_tx});
      chk("cyc_err", {31'b0, bus.err}, {31'b0, exp_err});
      if (exp_dout_known) chk("cyc_dout", {24'b0, bus.dout}, {24'b0, exp_dout});
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.rx_valid = 1'b0;
    bus.din = '0;
    model_reset();
    #12;
    rst_n = 1'b1;
    checking = 1'b1;
    @(posedge clk); #1;

    chk("reset_dout", {24'b0, bus.dout}, 32'h00);
    chk("reset_tx", {31'b0, bus.tx_valid}, 32'h0);
    chk("reset_err", {31'b0, bus.err}, 32'h0);

    // Unarmed read: mem[0] written through the reset wr_addr first
    cmd(WD, 8'h77);
    cmd(RD, 8'h00);
    chk("unarmed_err", {31'b0, bus.err}, 32'h1);
    chk("unarmed_tx", {31'b0, bus.tx_valid}, 32'h0);
    chk("unarmed_dout", {24'b0, bus.dout}, 32'h00);
    idle(1);
    chk("unarmed_err_gone", {31'b0, bus.err}, 32'h0);
    cmd(RA, 8'h00);
    cmd(RD, 8'h00);
    chk("armed_tx", {31'b0, bus.tx_valid}, 32'h1);
    chk("armed_err", {31'b0, bus.err}, 32'h0);
    chk("armed_dout", {24'b0, bus.dout}, 32'h77);

    // Single write/read
    cmd(WA, 8'h3C);
    cmd(WD, 8'hA5);
    cmd(RA, 8'h3C);
    cmd(RD, 8'hFF);
    chk("single_tx", {31'b0, bus.tx_valid}, 32'h1);
    chk("single_dout", {24'b0, bus.dout}, 32'hA5);
    idle(10);
    chk("single_hold_dout", {24'b0, bus.dout}, 32'hA5);
    chk("single_hold_tx", {31'b0, bus.tx_valid}, 32'h0);

    // Asynchronous reset pulse between edges
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_dout", {24'b0, bus.dout}, 32'h00);
    chk("async_rst_tx", {31'b0, bus.tx_valid}, 32'h0);
    chk("async_rst_err", {31'b0, bus.err}, 32'h0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Burst with wrap
    cmd(WA, 8'hFE);
    cmd(WD, 8'h11);
    cmd(WD, 8'h22);
    cmd(WD, 8'h33);
    cmd(RA, 8'hFE);
    cmd(RD, 8'h00);
    chk("burst0_tx", {31'b0, bus.tx_valid}, 32'h1);
    chk("burst0_dout", {24'b0, bus.dout}, 32'h11);
    cmd(RD, 8'h00);
    chk("burst1_tx", {31'b0, bus.tx_valid}, 32'h1);
    chk("burst1_dout", {24'b0, bus.dout}, 32'h22);
    cmd(RD, 8'h00);
    chk("burst2_tx", {31'b0, bus.tx_valid}, 32'h1);
    chk("burst2_dout", {24'b0, bus.dout}, 32'h33);
    cmd(RA, 8'h00);
    cmd(RD, 8'h00);
    chk("wrap_addr0", {24'b0, bus.dout}, 32'h33);

    // Independent pointers
    cmd(WA, 8'h20);
    cmd(WD, 8'hC3);
    cmd(WA, 8'h10);
    cmd(RA, 8'h20);
    cmd(WD, 8'h5A);
    cmd(RD, 8'h00);
    chk("indep_dout", {24'b0, bus.dout}, 32'hC3);
    chk("indep_wr_addr", {24'b0, dut.wr_addr}, 32'h11);
    chk("indep_rd_addr", {24'b0, dut.rd_addr}, 32'h21);
    cmd(RA, 8'h10);
    cmd(RD, 8'h00);
    chk("indep_mem10", {24'b0, bus.dout}, 32'h5A);
    idle(2);

    // Reset mid-read
    bus.din = {RD, 8'h00};
    bus.rx_valid = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1 bus.rx_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrd_tx", {31'b0, bus.tx_valid}, 32'h0);
    chk("midrd_dout", {24'b0, bus.dout}, 32'h00);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrd_tx_after", {31'b0, bus.tx_valid}, 32'h0);
    cmd(RD, 8'h00);
    chk("midrd_post_err", {31'b0, bus.err}, 32'h1);
    chk("midrd_post_tx", {31'b0, bus.tx_valid}, 32'h0);
    idle(2);

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

Command-decoding single-port RAM that sits directly downstream of the SPI slave. It consumes each 10-bit word the slave delivers on its receive interface, executes write-address, write-data, read-address and read-data commands against an internal byte-wide memory, and returns read bytes to the slave's transmit interface for shifting out on MISO. Write and read addresses auto-increment after each data access, so multi-byte transfers need only one address command.

## Interface
- MEM_DEPTH, 256: number of 8-bit memory words; must equal 2**ADDR_SIZE.
- ADDR_SIZE, 8: address width, 1..8; addresses are taken from din[ADDR_SIZE-1:0].

- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  10  command word from SPI slave rx_data; din[9:8] is the opcode, din[7:0] is the payload.
- rx_valid  input  1  din qualifier; every cycle with rx_valid=1 is exactly one command.
- dout  output  8  read data to SPI slave tx_data.
- tx_valid  output  1  one-cycle pulse marking a fresh dout.
- err  output  1  one-cycle pulse for a read-data command issued while unarmed.

## Operation
- Registers: wr_addr, rd_addr (ADDR_SIZE bits), rd_armed (1 bit), dout, tx_valid, err.
- Opcode decode, acted on only when rx_valid=1:
  - 00 WR_ADDR: wr_addr <= din[ADDR_SIZE-1:0].
  - 01 WR_DATA: mem[wr_addr] <= din[7:0]; wr_addr <= wr_addr+1.
  - 10 RD_ADDR: rd_addr <= din[ADDR_SIZE-1:0]; rd_armed <= 1.
  - 11 RD_DATA: if rd_armed, dout <= mem[rd_addr], tx_valid <= 1, rd_addr <= rd_addr+1. If not armed, err <= 1; dout, tx_valid and rd_addr are unchanged.
- Read control states: UNARMED (after reset) -> ARMED on the first RD_ADDR. ARMED persists across any number of RD_DATA, WR_ADDR and WR_DATA commands. Only reset returns to UNARMED.
- Address arithmetic: modulo MEM_DEPTH. The address after MEM_DEPTH-1 wraps to 0, with no flag.
- Payload bits above ADDR_SIZE-1 are ignored for address commands.
- WR_DATA always stores all 8 payload bits.
- Write and read address pointers are independent.
- A WR_DATA to an address, followed by an RD_DATA from that address on any later command, returns the new byte.
- The memory array is not reset. Contents are undefined until written.
- rx_valid=0: no state changes except tx_valid and err returning to 0.

## Timing
- Reset values: dout=0x00, tx_valid=0, err=0, wr_addr=0, rd_addr=0, rd_armed=0.
- Reset takes effect immediately on the falling edge of rst_n, independent of clk.
- WR_DATA: memory is updated at the rising edge at the end of the rx_valid cycle.
- RD_DATA: tx_valid=1 and dout=mem[rd_addr] in the cycle immediately after the rx_valid cycle (latency 1).
  - tx_valid is high for exactly one cycle.
  - dout holds its value until the next successful RD_DATA or reset.
- err: high for exactly the one cycle after the offending rx_valid cycle.
- Back-to-back commands on consecutive cycles are all executed. Two consecutive RD_DATA commands give tx_valid high for two cycles, with dout from rd_addr and then rd_addr+1.
- Reset asserted in the cycle between an RD_DATA and its tx_valid: tx_valid stays 0, dout=0x00, and the read is lost.
- Reset mid-burst: both pointers return to 0 and reads are UNARMED. The upstream side must reissue RD_ADDR.

## Test plan
- Reset check: rst_n=0 pulsed asynchronously between clk edges -> dout=0x00, tx_valid=0 and err=0 immediately, before the next edge.
- Single write/read: WR_ADDR 0x3C, WR_DATA 0xA5, RD_ADDR 0x3C, RD_DATA -> tx_valid=1 exactly one cycle after RD_DATA, with dout=0xA5; dout still 0xA5 ten cycles later.
- Burst with wrap: WR_ADDR 0xFE, then WR_DATA 0x11, 0x22, 0x33; then RD_ADDR 0xFE and three consecutive RD_DATA -> dout sequence 0x11, 0x22, 0x33 on three consecutive tx_valid cycles. Address 0x00 holds 0x33.
- Unarmed read: after reset, RD_DATA -> err=1 for one cycle, tx_valid=0, dout=0x00. Then RD_ADDR 0x00 followed by RD_DATA -> tx_valid=1 and err=0.
- Independent pointers: WR_ADDR 0x10, RD_ADDR 0x20, then WR_DATA 0x5A, RD_DATA -> dout=mem[0x20] (previously written 0xC3), mem[0x10]=0x5A; wr_addr=0x11, rd_addr=0x21.
- Reset mid-read: RD_DATA accepted, then rst_n low before the next clk edge -> tx_valid never rises, dout=0x00. A post-reset RD_DATA produces err=1.
